// File: rtl/mat_mult_seq.sv
// mat_mult_seq: steps a 4x4 product C = A*B through an external 4-term
// dot-product datapath and streams each C[i][j] row-major with its indices.
module mat_mult_seq #(
  parameter int WIDTH_A_80 = 9,
  parameter int WIDTH_B_80 = 8,
  parameter int WIDTH_SUM  = 11,
  parameter int DP_LAT     = 1
) (
  input  logic                  clk_80,
  input  logic                  rst_80,
  input  logic                  ld_en_80,
  input  logic                  ld_sel_80,
  input  logic [3:0]            ld_addr_80,
  input  logic [((WIDTH_A_80 > WIDTH_B_80) ? WIDTH_A_80 : WIDTH_B_80)-1:0] ld_data_80,
  input  logic                  start_80,
  output logic                  busy_80,
  output logic                  done_80,
  output logic [WIDTH_A_80-1:0] op_a0_80,
  output logic [WIDTH_A_80-1:0] op_a1_80,
  output logic [WIDTH_A_80-1:0] op_a2_80,
  output logic [WIDTH_A_80-1:0] op_a3_80,
  output logic [WIDTH_B_80-1:0] op_b0_80,
  output logic [WIDTH_B_80-1:0] op_b1_80,
  output logic [WIDTH_B_80-1:0] op_b2_80,
  output logic [WIDTH_B_80-1:0] op_b3_80,
  input  logic [WIDTH_SUM-1:0]  dp_result_80,
  output logic                  res_valid_80,
  input  logic                  res_ready_80,
  output logic [WIDTH_SUM-1:0]  res_data_80,
  output logic [1:0]            res_row_80,
  output logic [1:0]            res_col_80
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [2:0] LAT_MAX = 3'(DP_LAT);

  state_t state;
  logic [3:0] idx;
  logic [2:0] lat_cnt;

  logic [WIDTH_A_80-1:0] a_bank [16];
  logic [WIDTH_B_80-1:0] b_bank [16];

  logic [WIDTH_A_80-1:0] op_a  [4];
  logic [WIDTH_B_80-1:0] op_b  [4];
  logic [WIDTH_A_80-1:0] nxt_a [4];
  logic [WIDTH_B_80-1:0] nxt_b [4];

  logic [3:0] nxt_idx;
  logic       ld_ok;

  assign ld_ok   = ld_en_80 && !busy_80 && !start_80;
  assign nxt_idx = (state == S_IDLE) ? 4'd0 : idx + 4'd1;

  // Operand gather for the element about to be issued
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      nxt_a[k] = a_bank[{nxt_idx[3:2], 2'(k)}];
      nxt_b[k] = b_bank[{2'(k), nxt_idx[1:0]}];
    end
  end

  always_ff @(posedge clk_80) begin
    if (rst_80) begin
      for (int n = 0; n < 16; n++) begin
        a_bank[n] <= '0;
        b_bank[n] <= '0;
      end
    end else if (ld_ok) begin
      if (ld_sel_80)
        b_bank[ld_addr_80] <= ld_data_80[WIDTH_B_80-1:0];
      else
        a_bank[ld_addr_80] <= ld_data_80[WIDTH_A_80-1:0];
    end
  end

  always_ff @(posedge clk_80) begin
    if (rst_80) begin
      state        <= S_IDLE;
      idx          <= '0;
      lat_cnt      <= '0;
      busy_80      <= 1'b0;
      done_80      <= 1'b0;
      res_valid_80 <= 1'b0;
      res_data_80  <= '0;
      res_row_80   <= '0;
      res_col_80   <= '0;
      for (int k = 0; k < 4; k++) begin
        op_a[k] <= '0;
        op_b[k] <= '0;
      end
    end else begin
      done_80 <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_80) begin
            idx        <= nxt_idx;
            op_a       <= nxt_a;
            op_b       <= nxt_b;
            res_row_80 <= nxt_idx[3:2];
            res_col_80 <= nxt_idx[1:0];
            lat_cnt    <= '0;
            busy_80    <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (lat_cnt == LAT_MAX) begin
            res_data_80  <= dp_result_80;
            res_valid_80 <= 1'b1;
            state        <= S_OUT;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        S_OUT: begin
          if (res_ready_80) begin
            res_valid_80 <= 1'b0;
            if (idx == 4'd15) begin
              busy_80 <= 1'b0;
              done_80 <= 1'b1;
              state   <= S_DONE;
            end else begin
              idx        <= nxt_idx;
              op_a       <= nxt_a;
              op_b       <= nxt_b;
              res_row_80 <= nxt_idx[3:2];
              res_col_80 <= nxt_idx[1:0];
              lat_cnt    <= '0;
              state      <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign op_a0_80 = op_a[0];
  assign op_a1_80 = op_a[1];
  assign op_a2_80 = op_a[2];
  assign op_a3_80 = op_a[3];
  assign op_b0_80 = op_b[0];
  assign op_b1_80 = op_b[1];
  assign op_b2_80 = op_b[2];
  assign op_b3_80 = op_b[3];

endmodule
